// File: rtl/ctrl_decode_stage.sv
// Decode stage: turns a fetched word into a registered 21-bit control word,
// injecting interrupt-entry and undefined-instruction words when needed.
module ctrl_decode_stage #(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned IW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [31:0]        instruction,
    input  logic               stall,
    input  logic               flush,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               pc_supervisor,
    output logic               ctrl_valid,
    output logic [20:0]        ctrl_sig,
    output logic               irq_taken,
    output logic [IW-1:0]      irq_cause,
    output logic               expt,
    output logic [NUM_IRQ-1:0] pending
);

    localparam logic [20:0] EXPT_WORD = 21'h178008;
    localparam logic [20:0] IRQ_WORD  = 21'h13800C;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NEQ = 6'b110001;
    localparam logic [5:0] ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_LEZ = 6'b111101;
    localparam logic [5:0] ALU_LTZ = 6'b111011;
    localparam logic [5:0] ALU_GTZ = 6'b111111;

    logic [20:0]        r_ctrl_sig;
    logic               r_ctrl_valid;
    logic               r_irq_taken;
    logic [IW-1:0]      r_irq_cause;
    logic               r_expt;
    logic [NUM_IRQ-1:0] r_pending;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [2:0]  w_pcsrc;
    logic [1:0]  w_regdst;
    logic        w_regwr;
    logic        w_alusrc1;
    logic        w_alusrc2;
    logic [5:0]  w_alufun;
    logic        w_sign;
    logic        w_memwr;
    logic        w_memrd;
    logic [1:0]  w_memtoreg;
    logic        w_extop;
    logic        w_luop;
    logic        w_illegal;
    logic [20:0] w_dec;
    logic        w_unused;

    logic [NUM_IRQ-1:0] w_elig;
    logic [IW-1:0]      w_idx;
    logic               w_accept;
    logic               w_take;
    logic [NUM_IRQ-1:0] w_clear;

    assign w_op     = instruction[31:26];
    assign w_funct  = instruction[5:0];
    assign w_unused = ^instruction[25:6];

    // Instruction decode; every unused field stays 0
    always_comb begin
        w_pcsrc    = 3'd0;
        w_regdst   = 2'd0;
        w_regwr    = 1'b0;
        w_alusrc1  = 1'b0;
        w_alusrc2  = 1'b0;
        w_alufun   = ALU_ADD;
        w_sign     = 1'b0;
        w_memwr    = 1'b0;
        w_memrd    = 1'b0;
        w_memtoreg = 2'd0;
        w_extop    = 1'b0;
        w_luop     = 1'b0;
        w_illegal  = 1'b0;
        if (w_op == 6'h00) begin
            w_regwr = 1'b1;
            case (w_funct)
                6'h20: begin w_alufun = ALU_ADD; w_sign = 1'b1; end
                6'h21: w_alufun = ALU_ADD;
                6'h22: begin w_alufun = ALU_SUB; w_sign = 1'b1; end
                6'h23: w_alufun = ALU_SUB;
                6'h24: w_alufun = ALU_AND;
                6'h25: w_alufun = ALU_OR;
                6'h26: w_alufun = ALU_XOR;
                6'h27: w_alufun = ALU_NOR;
                6'h00: begin w_alufun = ALU_SLL; w_alusrc1 = 1'b1; end
                6'h02: begin w_alufun = ALU_SRL; w_alusrc1 = 1'b1; end
                6'h03: begin w_alufun = ALU_SRA; w_alusrc1 = 1'b1; end
                6'h2A: begin w_alufun = ALU_LT; w_sign = 1'b1; end
                6'h08: begin w_pcsrc = 3'd3; w_regwr = 1'b0; end
                6'h09: begin w_pcsrc = 3'd3; w_memtoreg = 2'd2; end
                default: w_illegal = 1'b1;
            endcase
        end else begin
            case (w_op)
                6'h23: begin
                    w_regdst = 2'd1; w_regwr = 1'b1; w_alusrc2 = 1'b1; w_sign = 1'b1;
                    w_memrd = 1'b1; w_memtoreg = 2'd1; w_extop = 1'b1;
                end
                6'h2B: begin w_alusrc2 = 1'b1; w_sign = 1'b1; w_memwr = 1'b1; w_extop = 1'b1; end
                6'h0F: begin w_regdst = 2'd1; w_regwr = 1'b1; w_alusrc2 = 1'b1; w_luop = 1'b1; end
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: begin
                    w_regdst  = 2'd1;
                    w_regwr   = 1'b1;
                    w_alusrc2 = 1'b1;
                    w_sign    = (w_op == 6'h08) || (w_op == 6'h0A);
                    w_extop   = (w_op != 6'h0C) && (w_op != 6'h0D);
                    w_alufun  = (w_op == 6'h0C) ? ALU_AND :
                                (w_op == 6'h0D) ? ALU_OR  :
                                (w_op[3:1] == 3'b101) ? ALU_LT : ALU_ADD;
                end
                6'h04, 6'h05, 6'h06, 6'h07, 6'h01: begin
                    w_pcsrc  = 3'd1;
                    w_sign   = 1'b1;
                    w_extop  = 1'b1;
                    w_alufun = (w_op == 6'h04) ? ALU_EQ  :
                               (w_op == 6'h05) ? ALU_NEQ :
                               (w_op == 6'h06) ? ALU_LEZ :
                               (w_op == 6'h07) ? ALU_GTZ : ALU_LTZ;
                end
                6'h02: w_pcsrc = 3'd2;
                6'h03: begin w_pcsrc = 3'd2; w_regdst = 2'd2; w_regwr = 1'b1; w_memtoreg = 2'd2; end
                default: w_illegal = 1'b1;
            endcase
        end
        w_dec = w_illegal ? EXPT_WORD :
                {w_pcsrc, w_regdst, w_regwr, w_alusrc1, w_alusrc2, w_alufun,
                 w_sign, w_memwr, w_memrd, w_memtoreg, w_extop, w_luop};
    end

    // Lowest unmasked pending source wins
    always_comb begin
        w_idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (w_elig[i]) w_idx = IW'(i);
        end
    end

    assign w_elig   = r_pending & ~irq_mask;
    assign w_accept = instr_valid & ~stall & ~flush;
    assign w_take   = w_accept & ~pc_supervisor & (|w_elig);
    assign w_clear  = w_take ? (NUM_IRQ'(1) << w_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_sig   <= '0;
            r_ctrl_valid <= 1'b0;
            r_irq_taken  <= 1'b0;
            r_irq_cause  <= '0;
            r_expt       <= 1'b0;
            r_pending    <= '0;
        end else begin
            // New requests always win over the clear of a serviced source
            r_pending <= (r_pending & ~w_clear) | irq;
            if (flush || (!stall && !instr_valid)) begin
                r_ctrl_sig   <= '0;
                r_ctrl_valid <= 1'b0;
                r_irq_taken  <= 1'b0;
                r_irq_cause  <= '0;
                r_expt       <= 1'b0;
            end else if (!stall) begin
                r_ctrl_valid <= 1'b1;
                r_irq_taken  <= w_take;
                r_irq_cause  <= w_take ? w_idx : '0;
                r_ctrl_sig   <= w_take ? IRQ_WORD : w_dec;
                r_expt       <= w_take ? 1'b0 : w_illegal;
            end
        end
    end

    assign ctrl_sig   = r_ctrl_sig;
    assign ctrl_valid = r_ctrl_valid;
    assign irq_taken  = r_irq_taken;
    assign irq_cause  = r_irq_cause;
    assign expt       = r_expt;
    assign pending    = r_pending;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: driver queues expected outputs,
// monitor pops and compares one entry per clock.
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;
    logic [3:0]  irq;
    logic [3:0]  irq_mask;
    logic        pc_supervisor;
    logic        ctrl_valid;
    logic [20:0] ctrl_sig;
    logic        irq_taken;
    logic [1:0]  irq_cause;
    logic        expt;
    logic [3:0]  pending;

    typedef struct {
        logic [20:0] sig;
        logic        val;
        logic        tk;
        logic [1:0]  cause;
        logic        ex;
        logic [3:0]  pend;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    ctrl_decode_stage #(.NUM_IRQ(4)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
        .stall(stall), .flush(flush), .irq(irq), .irq_mask(irq_mask),
        .pc_supervisor(pc_supervisor), .ctrl_valid(ctrl_valid), .ctrl_sig(ctrl_sig),
        .irq_taken(irq_taken), .irq_cause(irq_cause), .expt(expt), .pending(pending)
    );

    always #5 clk = ~clk;

    // Monitor: one registered result per clock
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (ctrl_sig !== e.sig || ctrl_valid !== e.val || irq_taken !== e.tk ||
                    irq_cause !== e.cause || expt !== e.ex || pending !== e.pend) begin
                    errors++;
                    $display("FAIL %s: got sig=%06h v=%b tk=%b cause=%0d ex=%b pend=%b, want sig=%06h v=%b tk=%b cause=%0d ex=%b pend=%b",
                             e.name, ctrl_sig, ctrl_valid, irq_taken, irq_cause, expt, pending,
                             e.sig, e.val, e.tk, e.cause, e.ex, e.pend);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                        input logic st, input logic fl, input logic [3:0] rq,
                        input logic [3:0] mk, input logic sup,
                        input logic [20:0] e_sig, input logic e_val, input logic e_tk,
                        input logic [1:0] e_cause, input logic e_ex, input logic [3:0] e_pend,
                        input string nm);
        exp_t e;
        reset = rst; instr_valid = v; instruction = ins; stall = st; flush = fl;
        irq = rq; irq_mask = mk; pc_supervisor = sup;
        e.sig = e_sig; e.val = e_val; e.tk = e_tk; e.cause = e_cause;
        e.ex = e_ex; e.pend = e_pend; e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD = 32'h00221820;
    localparam logic [31:0] LW  = 32'h8C220004;
    localparam logic [31:0] JAL = 32'h0C000010;
    localparam logic [31:0] BAD = 32'hFC000000;

    initial begin
        //   rst v  instr         st fl irq     mask    sup  sig        v  tk c  ex pend
        step(1, 0, 32'h0,        0, 0, 4'b1111, 4'b0000, 0, 21'h000000, 0, 0, 0, 0, 4'b0000, "reset");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h008040, 1, 0, 0, 0, 4'b0000, "add");
        step(0, 1, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 21'h00D000, 1, 0, 0, 0, 4'b0000, "nop");
        step(0, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 21'h000000, 0, 0, 0, 0, 4'b0000, "bubble");
        step(0, 1, BAD,          0, 0, 4'b0000, 4'b0000, 0, 21'h178008, 1, 0, 0, 1, 4'b0000, "illegal_op");
        step(0, 1, 32'h0000003F, 0, 0, 4'b0000, 4'b0000, 0, 21'h178008, 1, 0, 0, 1, 4'b0000, "illegal_funct");
        step(0, 1, LW,           0, 0, 4'b0000, 4'b0000, 0, 21'h01A056, 1, 0, 0, 0, 4'b0000, "lw");
        step(0, 1, 32'hAC220004, 0, 0, 4'b0000, 4'b0000, 0, 21'h002062, 1, 0, 0, 0, 4'b0000, "sw");
        step(0, 1, 32'h10220003, 0, 0, 4'b0000, 4'b0000, 0, 21'h0419C2, 1, 0, 0, 0, 4'b0000, "beq");
        step(0, 1, JAL,          0, 0, 4'b0000, 4'b0000, 0, 21'h0A8008, 1, 0, 0, 0, 4'b0000, "jal");
        step(0, 1, 32'h03E00008, 0, 0, 4'b0000, 4'b0000, 0, 21'h0C0000, 1, 0, 0, 0, 4'b0000, "jr");
        step(0, 1, 32'h3C011234, 0, 0, 4'b0000, 4'b0000, 0, 21'h01A001, 1, 0, 0, 0, 4'b0000, "lui");
        step(0, 1, 32'h0022182A, 0, 0, 4'b0000, 4'b0000, 0, 21'h009AC0, 1, 0, 0, 0, 4'b0000, "slt");
        step(0, 1, 32'h34221234, 0, 0, 4'b0000, 4'b0000, 0, 21'h01AF00, 1, 0, 0, 0, 4'b0000, "ori");
        // Two simultaneous requests serviced one per accept, lowest first
        step(0, 1, ADD,          0, 0, 4'b1010, 4'b0000, 0, 21'h008040, 1, 0, 0, 0, 4'b1010, "irq_pulse");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h13800C, 1, 1, 1, 0, 4'b1000, "irq_cause1");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h13800C, 1, 1, 3, 0, 4'b0000, "irq_cause3");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h008040, 1, 0, 0, 0, 4'b0000, "post_irq");
        // Masked, then deferred by supervisor mode, then taken
        step(0, 1, ADD,          0, 0, 4'b0001, 4'b0001, 0, 21'h008040, 1, 0, 0, 0, 4'b0001, "mask_set");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0001, 0, 21'h008040, 1, 0, 0, 0, 4'b0001, "masked_hold");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 1, 21'h008040, 1, 0, 0, 0, 4'b0001, "supervisor");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h13800C, 1, 1, 0, 0, 4'b0000, "unsupervised");
        // Level still high on the take cycle keeps the bit pending
        step(0, 1, ADD,          0, 0, 4'b0100, 4'b0000, 0, 21'h008040, 1, 0, 0, 0, 4'b0100, "lvl_set");
        step(0, 1, ADD,          0, 0, 4'b0100, 4'b0000, 0, 21'h13800C, 1, 1, 2, 0, 4'b0100, "lvl_held");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h13800C, 1, 1, 2, 0, 4'b0000, "lvl_clear");
        // Stall holds outputs while collecting requests; flush overrides stall
        step(0, 1, LW,           0, 0, 4'b0000, 4'b0000, 0, 21'h01A056, 1, 0, 0, 0, 4'b0000, "pre_stall");
        step(0, 1, ADD,          1, 0, 4'b0100, 4'b0000, 0, 21'h01A056, 1, 0, 0, 0, 4'b0100, "stall1");
        step(0, 1, ADD,          1, 0, 4'b0000, 4'b0000, 0, 21'h01A056, 1, 0, 0, 0, 4'b0100, "stall2");
        step(0, 1, ADD,          1, 0, 4'b0000, 4'b0000, 0, 21'h01A056, 1, 0, 0, 0, 4'b0100, "stall3");
        step(0, 1, ADD,          1, 1, 4'b0000, 4'b0000, 0, 21'h000000, 0, 0, 0, 0, 4'b0100, "flush");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h13800C, 1, 1, 2, 0, 4'b0000, "after_flush");
        // Reset during a stall drops the held word and ignores irq
        step(0, 1, JAL,          0, 0, 4'b0000, 4'b0000, 0, 21'h0A8008, 1, 0, 0, 0, 4'b0000, "pre_rst");
        step(0, 1, ADD,          1, 0, 4'b0000, 4'b0000, 0, 21'h0A8008, 1, 0, 0, 0, 4'b0000, "stall_hold");
        step(1, 1, ADD,          1, 0, 4'b0010, 4'b0000, 0, 21'h000000, 0, 0, 0, 0, 4'b0000, "rst_stall");
        step(0, 1, ADD,          1, 0, 4'b0000, 4'b0000, 0, 21'h000000, 0, 0, 0, 0, 4'b0000, "stall_after_rst");
        // All four at once with the low half masked
        step(0, 1, ADD,          0, 0, 4'b1111, 4'b0000, 0, 21'h008040, 1, 0, 0, 0, 4'b1111, "all_set");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0011, 0, 21'h13800C, 1, 1, 2, 0, 4'b1011, "mask_low");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h13800C, 1, 1, 0, 0, 4'b1010, "unmask_low");
        step(0, 1, BAD,          0, 0, 4'b0000, 4'b0000, 0, 21'h13800C, 1, 1, 1, 0, 4'b1000, "irq_over_expt");
        step(0, 0, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h000000, 0, 0, 0, 0, 4'b1000, "idle_no_take");
        step(0, 1, ADD,          0, 0, 4'b0000, 4'b0000, 0, 21'h13800C, 1, 1, 3, 0, 4'b0000, "last_irq");
        step(0, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 21'h000000, 0, 0, 0, 0, 4'b0000, "drain");

        @(posedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
